// File: rtl/exe_alu_mc_pkg.sv
// Shared command codes, FSM state type and status-flag bit positions for the execute-stage ALU.
package exe_pkg;
  localparam logic [3:0] MOV_EXE = 4'b0001;
  localparam logic [3:0] MVN_EXE = 4'b1001;
  localparam logic [3:0] ADD_EXE = 4'b0010;
  localparam logic [3:0] ADC_EXE = 4'b0011;
  localparam logic [3:0] SUB_EXE = 4'b0100;
  localparam logic [3:0] SBC_EXE = 4'b0101;
  localparam logic [3:0] AND_EXE = 4'b0110;
  localparam logic [3:0] ORR_EXE = 4'b0111;
  localparam logic [3:0] EOR_EXE = 4'b1000;
  localparam logic [3:0] MUL_EXE = 4'b1010;
  localparam logic [3:0] MLA_EXE = 4'b1011;

  typedef enum logic [1:0] {IDLE = 2'd0, MRUN = 2'd1, DONE = 2'd2} state_t;

  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  function automatic logic is_mul(input logic [3:0] cmd);
    return (cmd == MUL_EXE) || (cmd == MLA_EXE);
  endfunction
endpackage

// File: rtl/exe_alu_mc_if.sv
// Command/result handshake bundle between the ID/EXE register, the ALU and the EXE/MEM register.
interface exe_alu_mc_if #(parameter int DATA_W = 32) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val3;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [3:0]        SR;

  modport master (output in_valid, exe_cmd, val1, val2, val3, cin, out_ready,
                  input  in_ready, out_valid, result, SR);
  modport slave  (input  in_valid, exe_cmd, val1, val2, val3, cin, out_ready,
                  output in_ready, out_valid, result, SR);
endinterface

// File: rtl/exe_alu_mc_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// Latency DATA_W/MUL_BPC cycles after start; product is valid in the cycle done is high.
module mul_iter #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] mcand_in,
  input  logic [DATA_W-1:0] mplier_in,
  input  logic [DATA_W-1:0] addend_in,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int STEPS = DATA_W / MUL_BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] partial;

  // product is the accumulator after this cycle's step, so the last step needs no extra cycle
  always_comb begin
    partial = mcand * DATA_W'(mplier[MUL_BPC-1:0]);
    product = acc + partial;
    done    = busy && (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= addend_in;
      mcand  <= mcand_in;
      mplier <= mplier_in;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << MUL_BPC;
      mplier <= mplier >> MUL_BPC;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/exe_alu_mc.sv
// Execute-stage ALU with registered result/flags and iterative MUL/MLA.
// Latency 1 (MUL/MLA: DATA_W/MUL_BPC+1); holds result while out_ready=0, in_ready drops while busy.
module exe_alu_mc
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  exe_alu_mc_if.slave bus
);
  state_t            state, state_nxt;
  logic              in_ready, out_valid, accept;
  logic              alu_load, mul_start, mul_load, mul_done;
  logic              cin_q;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        sr_q;

  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_known;
  logic [3:0]        alu_sr, mul_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul(bus.exe_cmd) ? MRUN : DONE;
      MRUN:    if (mul_done) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = is_mul(bus.exe_cmd) ? MRUN : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    out_valid = (state == DONE);
    accept    = bus.in_valid && in_ready && !flush;
    mul_start = accept && is_mul(bus.exe_cmd);
    alu_load  = accept && !is_mul(bus.exe_cmd);
    mul_load  = (state == MRUN) && mul_done && !flush;
  end

  // Subtraction carries out NOT-borrow, matching the ARM status-register convention
  always_comb begin
    alu_sum   = '0;
    alu_res   = '0;
    alu_c     = bus.cin;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (bus.exe_cmd)
      MOV_EXE: alu_res = bus.val2;
      MVN_EXE: alu_res = ~bus.val2;
      ADD_EXE, ADC_EXE: begin
        alu_sum = {1'b0, bus.val1} + {1'b0, bus.val2}
                + ((bus.exe_cmd == ADC_EXE) ? {{DATA_W{1'b0}}, bus.cin} : '0);
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
        alu_v   = (bus.val1[DATA_W-1] == bus.val2[DATA_W-1])
               && (alu_res[DATA_W-1] != bus.val1[DATA_W-1]);
      end
      SUB_EXE, SBC_EXE: begin
        alu_sum = {1'b0, bus.val1} - {1'b0, bus.val2}
                - ((bus.exe_cmd == SBC_EXE) ? {{DATA_W{1'b0}}, ~bus.cin} : '0);
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = ~alu_sum[DATA_W];
        alu_v   = (bus.val1[DATA_W-1] != bus.val2[DATA_W-1])
               && (alu_res[DATA_W-1] != bus.val1[DATA_W-1]);
      end
      AND_EXE: alu_res = bus.val1 & bus.val2;
      ORR_EXE: alu_res = bus.val1 | bus.val2;
      EOR_EXE: alu_res = bus.val1 ^ bus.val2;
      default: alu_known = 1'b0;
    endcase

    alu_sr = '0;
    if (alu_known) begin
      alu_sr[SR_Z] = (alu_res == '0);
      alu_sr[SR_C] = alu_c;
      alu_sr[SR_N] = alu_res[DATA_W-1];
      alu_sr[SR_V] = alu_v;
    end

    mul_sr       = '0;
    mul_sr[SR_Z] = (mul_product == '0);
    mul_sr[SR_C] = cin_q;
    mul_sr[SR_N] = mul_product[DATA_W-1];
  end

  mul_iter #(.DATA_W(DATA_W), .MUL_BPC(MUL_BPC)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .abort     (flush),
    .mcand_in  (bus.val1),
    .mplier_in (bus.val2),
    .addend_in ((bus.exe_cmd == MLA_EXE) ? bus.val3 : '0),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      sr_q     <= '0;
      cin_q    <= 1'b0;
    end else begin
      if (alu_load) begin
        result_q <= alu_res;
        sr_q     <= alu_sr;
      end else if (mul_load) begin
        result_q <= mul_product;
        sr_q     <= mul_sr;
      end
      if (mul_start) cin_q <= bus.cin;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.SR        = sr_q;
endmodule

// File: tb/tb_exe_alu_mc.sv
// Directed bench for exe_alu_mc: reference model feeds a scoreboard queue checked at each result.
module tb_exe_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic flush4 = 1'b0;

  exe_alu_mc_if #(.DATA_W(32)) ifc ();
  exe_alu_mc_if #(.DATA_W(32)) ifc4 ();

  exe_alu_mc #(.DATA_W(32), .MUL_BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc));
  exe_alu_mc #(.DATA_W(32), .MUL_BPC(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .bus(ifc4));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lat;
  bit rdy_seen;
  logic [35:0] sb_q[$];

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent 64-bit reference: {result[31:0], Z, C, N, V}
  function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic ci);
    logic [63:0] u;
    longint s;
    logic [31:0] r;
    logic cf, vf, known;
    logic [63:0] bin;
    known = 1'b1; cf = ci; vf = 1'b0; r = '0; u = '0; s = 0;
    bin = {63'b0, ~ci};
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        u = {32'b0, a} + {32'b0, b} + ((cmd == 4'b0011) ? {63'b0, ci} : 64'd0);
        r = u[31:0];
        cf = u[32];
        s = longint'($signed(a)) + longint'($signed(b)) + ((cmd == 4'b0011) ? longint'(ci) : 0);
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        if (cmd == 4'b0100) bin = 64'd0;
        cf = ({32'b0, a} >= ({32'b0, b} + bin));
        r = a - b - bin[31:0];
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b1010, 4'b1011: begin
        u = {32'b0, a} * {32'b0, b} + ((cmd == 4'b1011) ? {32'b0, c} : 64'd0);
        r = u[31:0];
      end
      default: known = 1'b0;
    endcase
    return known ? {r, (r == 32'd0), cf, r[31], vf} : 36'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic ci, input bit push);
    int w;
    ifc.in_valid = 1'b1;
    ifc.exe_cmd = cmd;
    ifc.val1 = a;
    ifc.val2 = b;
    ifc.val3 = c;
    ifc.cin = ci;
    if (push) sb_q.push_back(model(cmd, a, b, c, ci));
    w = 0;
    while (!ifc.in_ready && w < 100) begin
      step();
      w++;
    end
    check("accept_wait", {35'b0, ifc.in_ready}, 36'd1);
    step();
    ifc.in_valid = 1'b0;
    ifc.val1 = $urandom;
    ifc.val2 = $urandom;
    ifc.val3 = $urandom;
    ifc.cin = ~ci;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    lat = 1;
    rdy_seen = 1'b0;
    while (!ifc.out_valid && lat < 100) begin
      if (ifc.in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, "_lat"}, 36'(lat), 36'(exp_lat));
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      check({tag, "_res"}, {ifc.result, ifc.SR}, sb_q.pop_front());
    end
  endtask

  logic [3:0]  t_cmd[10] = '{4'b0001, 4'b1001, 4'b0011, 4'b0100, 4'b0101,
                             4'b0110, 4'b0111, 4'b1000, 4'b1111, 4'b0000};
  logic [31:0] t_a[10]   = '{32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                             32'hF0F0_F0F0, 32'h0F00_0000, 32'hAAAA_5555, 32'h1, 32'h2};
  logic [31:0] t_b[10]   = '{32'h0, 32'h0000_00FF, 32'h0, 32'd2, 32'd1,
                             32'h0FF0_0FF0, 32'h0000_00F0, 32'hAAAA_5555, 32'h1, 32'h3};
  logic        t_c[10]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bit seen;
    ifc.in_valid = 0; ifc.exe_cmd = 0; ifc.val1 = 0; ifc.val2 = 0; ifc.val3 = 0;
    ifc.cin = 0; ifc.out_ready = 1;
    ifc4.in_valid = 0; ifc4.exe_cmd = 0; ifc4.val1 = 0; ifc4.val2 = 0; ifc4.val3 = 0;
    ifc4.cin = 0; ifc4.out_ready = 1;

    step(); step();
    check("rst_state", {ifc.result, ifc.SR}, 36'h0);
    check("rst_valid_ready", {34'b0, ifc.out_valid, ifc.in_ready}, 36'h0);
    rst = 1'b1;
    step();
    check("post_rst_ready", {35'b0, ifc.in_ready}, 36'd1);

    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1);
    check("add_ovf_const", {ifc.out_valid, ifc.result, ifc.SR}, {1'b1, 32'h8000_0000, 4'b0011});
    wait_out("add_ovf", 1);
    step();

    send(4'b0100, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1);
    check("sub_eq_const", {32'h0, ifc.SR}, {32'h0, 4'b1100});
    wait_out("sub_eq", 1);
    step();
    send(4'b0101, 32'd3, 32'd1, 32'h0, 1'b0, 1'b1);
    check("sbc_const", {ifc.result, ifc.SR}, {32'd1, 4'b0100});
    wait_out("sbc", 1);
    step();

    for (int i = 0; i < 10; i++) begin
      send(t_cmd[i], t_a[i], t_b[i], 32'h0, t_c[i], 1'b1);
      wait_out($sformatf("op%0d", i), 1);
      step();
    end

    send(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b1, 1'b1);
    wait_out("mul", 33);
    check("mul_const", {ifc.result, ifc.SR}, {32'hFFFF_FFFF, 4'b0110});
    check("mul_busy_ready", {35'b0, rdy_seen}, 36'd0);
    step();

    send(4'b1011, 32'd3, 32'd4, 32'hFFFF_FFF4, 1'b0, 1'b1);
    wait_out("mla", 33);
    check("mla_const", {ifc.result, ifc.SR}, {32'h0, 4'b1000});
    step();

    ifc4.in_valid = 1; ifc4.exe_cmd = 4'b1011; ifc4.val1 = 32'd3; ifc4.val2 = 32'd4;
    ifc4.val3 = 32'hFFFF_FFF4; ifc4.cin = 1'b0;
    check("mla4_ready", {35'b0, ifc4.in_ready}, 36'd1);
    step();
    ifc4.in_valid = 0; ifc4.val1 = 32'd7;
    lat = 1;
    while (!ifc4.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("mla4_lat", 36'(lat), 36'd9);
    check("mla4_res", {ifc4.result, ifc4.SR},
          model(4'b1011, 32'd3, 32'd4, 32'hFFFF_FFF4, 1'b0));
    step();

    ifc.out_ready = 1'b0;
    send(4'b0001, 32'h0, 32'h0000_00A5, 32'h0, 1'b1, 1'b1);
    wait_out("mov_bp", 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold%0d", i), {ifc.result, ifc.SR}, {32'h0000_00A5, 4'b0100});
      check($sformatf("bp_flow%0d", i), {34'b0, ifc.out_valid, ifc.in_ready}, 36'b10);
    end
    ifc.in_valid = 1; ifc.exe_cmd = 4'b0010; ifc.val1 = 32'd1; ifc.val2 = 32'd1; ifc.cin = 1'b0;
    sb_q.push_back(model(4'b0010, 32'd1, 32'd1, 32'h0, 1'b0));
    ifc.out_ready = 1'b1;
    #1;
    check("b2b_ready", {35'b0, ifc.in_ready}, 36'd1);
    step();
    ifc.in_valid = 0;
    check("b2b_const", {ifc.out_valid, ifc.result, ifc.SR}, {1'b1, 32'd2, 4'b0000});
    wait_out("b2b", 1);
    step();

    flush = 1'b1;
    send(4'b0010, 32'd9, 32'd9, 32'h0, 1'b0, 1'b0);
    flush = 1'b0;
    check("flush_accept", {34'b0, ifc.out_valid, ifc.in_ready}, 36'b01);

    send(4'b1010, 32'd123, 32'd456, 32'h0, 1'b0, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_mrun", {34'b0, ifc.out_valid, ifc.in_ready}, 36'b01);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (ifc.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {35'b0, seen}, 36'd0);

    send(4'b1010, 32'd77, 32'd88, 32'h0, 1'b1, 1'b0);
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("rst_mid_out", {ifc.out_valid, ifc.in_ready, ifc.result, ifc.SR}, 38'h0);
    step();
    rst = 1'b1;
    step();
    send(4'b0010, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1);
    wait_out("add_after_rst", 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/exe_alu_mc.md
Name: exe_alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle execute-stage ALU.
- Generalises the datapath to DATA_W bits and registers the result and status flags.
- Adds iterative multi-cycle MUL/MLA with valid/ready flow control and a synchronous flush.
- Sits in the EXE stage between the ID/EXE and EXE/MEM pipeline registers; the hazard unit stalls ID/EXE on in_ready=0.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- MUL_BPC, 1, multiplier bits retired per cycle; must divide DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort (branch taken); drops any in-flight op.
- in_valid  in  1  operands/command valid.
- in_ready  out  1  block can accept this cycle.
- exe_cmd  in  4  operation code.
- val1  in  DATA_W  Rn operand.
- val2  in  DATA_W  shifter operand / Rm.
- val3  in  DATA_W  accumulate operand (MLA only).
- cin  in  1  carry-in from status register.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  DATA_W  operation result.
- SR  out  4  flags {Z,C,N,V}.

Behaviour:
- Reset (rst=0, async): state=IDLE, out_valid=0, result=0, SR=0, in_ready=0 while asserted, then 1.
- exe_cmd encoding:
  - MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, MUL 1010, MLA 1011.
  - Any other code: result=0, SR=0, single-cycle.
- Accept occurs when in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- States and transitions:
  - IDLE: on accept of a single-cycle op, go to DONE, registering result/SR at that edge (latency 1).
  - IDLE: on accept of MUL/MLA, go to MRUN.
  - MRUN: runs DATA_W/MUL_BPC cycles, then goes to DONE. Latency DATA_W/MUL_BPC+1 from accept to out_valid.
  - DONE: out_valid=1. result and SR are held stable while out_ready=0.
  - DONE & out_ready & new accept: reload as from IDLE (back-to-back, no bubble).
  - DONE & out_ready & no accept: go to IDLE.
- Arithmetic: all width-extended by one bit.
- Carry flag:
  - ADD/ADC: C = carry out of bit DATA_W-1.
  - SUB: computes val1-val2. SBC: computes val1-val2-(~cin). For both, C = NOT borrow (ARM semantics).
- Overflow flag:
  - ADD/ADC: V=1 iff operand signs equal and result sign differs.
  - SUB/SBC: V=1 iff operand signs differ and result sign differs from val1.
- Logic ops and MOV/MVN: C=cin, V=0.
- MUL/MLA:
  - result = low DATA_W bits of val1*val2 (+val3 for MLA), unsigned shift-add.
  - C=cin captured at accept, V=0.
- All ops: N=result[DATA_W-1]; Z=(result==0).
- Operands and cin are captured at accept; later input changes are ignored.
- flush=1: state goes to IDLE and out_valid=0 at the next edge, including mid-MRUN. An accept in the same cycle as flush is discarded. flush has priority over out_ready.
- rst asserted mid-operation: immediate return to the reset values.

Decomposition:
- Shared package exe_pkg:
  - exe_cmd localparams (including MUL_EXE, MLA_EXE).
  - State enum {IDLE, MRUN, DONE}.
  - SR bit-index constants Z=3, C=2, N=1, V=0.
- One sub-module, mul_iter:
  - Parametrised DATA_W/MUL_BPC; holds the accumulator, multiplicand and step counter.
  - Interface: start, done, product.

Test Plan:
- ADD val1=0x7FFFFFFF, val2=0x00000001 -> one cycle later: out_valid=1, result=0x80000000, SR=4'b0011.
- SUB val1=5, val2=5 -> result=0, SR=4'b1100; SBC val1=3, val2=1, cin=0 -> result=1, SR=4'b0100.
- MUL val1=0x0000FFFF, val2=0x00010001, cin=1 -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFF, SR=4'b0110; in_ready=0 throughout MRUN.
- MLA val1=3, val2=4, val3=0xFFFFFFF4 -> result=0, SR=4'b1000 (cin=0); rerun with MUL_BPC=4 -> latency 9.
- Backpressure: MOV val2=0xA5 with out_ready=0 for 5 cycles -> result/SR stable, in_ready=0. Then out_ready=1 with a pending ADD 1+1 -> ADD accepted the same cycle, and 2 appears the next cycle with no bubble.
- flush at MRUN cycle 10 -> out_valid never rises, state IDLE next cycle. rst pulsed low mid-MUL -> outputs 0 immediately; a fresh ADD completes correctly.
